// File: rtl/sa_read_arbiter_pkg.sv
// Shared AXI field widths and default sizing for the interconnect blocks,
// plus the AR output stage state type used by the per-slave read arbiter.
package sa_read_arbiter_pkg;

   localparam int unsigned MST_AMT_DEF         = 2;
   localparam int unsigned OUTSTANDING_AMT_DEF = 8;
   localparam int unsigned DATA_WIDTH_DEF      = 32;
   localparam int unsigned ADDR_WIDTH_DEF      = 32;
   localparam int unsigned TRANS_MST_ID_W      = 5;
   localparam int unsigned TRANS_BURST_W       = 2;
   localparam int unsigned TRANS_DATA_LEN_W    = 3;
   localparam int unsigned TRANS_DATA_SIZE_W   = 3;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_PEND = 1'b1
   } ar_state_e;

   // Circular successor of a dispatcher index.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned amt);
      return (idx + 1 >= amt) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sa_read_arbiter_if.sv
// Dispatcher-side and slave-side AR/R signals of one slave's read arbiter.
// The arbiter uses the slave modport; the surrounding fabric uses master.
interface sa_read_arbiter_if #(
   parameter int unsigned MST_AMT    = sa_read_arbiter_pkg::MST_AMT_DEF,
   parameter int unsigned DATA_WIDTH = sa_read_arbiter_pkg::DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = sa_read_arbiter_pkg::ADDR_WIDTH_DEF
);
   import sa_read_arbiter_pkg::*;

   logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_ARID_i;
   logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_ARADDR_i;
   logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_ARBURST_i;
   logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_ARLEN_i;
   logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_ARSIZE_i;
   logic [MST_AMT-1:0]                   dsp_ARVALID_i;
   logic [MST_AMT-1:0]                   dsp_AR_outst_full_i;
   logic [MST_AMT-1:0]                   dsp_ARREADY_o;
   logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_RID_o;
   logic [DATA_WIDTH*MST_AMT-1:0]        dsp_RDATA_o;
   logic [MST_AMT-1:0]                   dsp_RLAST_o;
   logic [MST_AMT-1:0]                   dsp_RVALID_o;
   logic [MST_AMT-1:0]                   dsp_RREADY_i;

   logic [TRANS_MST_ID_W-1:0]            s_ARID_o;
   logic [ADDR_WIDTH-1:0]                s_ARADDR_o;
   logic [TRANS_BURST_W-1:0]             s_ARBURST_o;
   logic [TRANS_DATA_LEN_W-1:0]          s_ARLEN_o;
   logic [TRANS_DATA_SIZE_W-1:0]         s_ARSIZE_o;
   logic                                 s_ARVALID_o;
   logic                                 s_ARREADY_i;
   logic [TRANS_MST_ID_W-1:0]            s_RID_i;
   logic [DATA_WIDTH-1:0]                s_RDATA_i;
   logic                                 s_RLAST_i;
   logic                                 s_RVALID_i;
   logic                                 s_RREADY_o;

   modport slave (
      input  dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
      input  dsp_ARVALID_i, dsp_AR_outst_full_i, dsp_RREADY_i,
      output dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o,
      output s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o, s_ARVALID_o,
      input  s_ARREADY_i, s_RID_i, s_RDATA_i, s_RLAST_i, s_RVALID_i,
      output s_RREADY_o
   );

   modport master (
      output dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
      output dsp_ARVALID_i, dsp_AR_outst_full_i, dsp_RREADY_i,
      input  dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o,
      input  s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o, s_ARVALID_o,
      output s_ARREADY_i, s_RID_i, s_RDATA_i, s_RLAST_i, s_RVALID_i,
      input  s_RREADY_o
   );

endinterface

// File: rtl/sa_order_fifo.sv
// Synchronous FIFO of dispatcher indices recording AR acceptance order.
// A push is refused only when full before any same-cycle pop.
module sa_order_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sa_read_arbiter.sv
// Per-slave read arbiter: round-robin AR grant into a registered AR stage,
// R bursts steered back to dispatchers in AR acceptance order.
module sa_read_arbiter
   import sa_read_arbiter_pkg::*;
#(
   parameter int unsigned MST_AMT         = MST_AMT_DEF,
   parameter int unsigned OUTSTANDING_AMT = OUTSTANDING_AMT_DEF,
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
   input  logic               ACLK_i,
   input  logic               ARESET_i,
   sa_read_arbiter_if.slave   bus
);
   localparam int unsigned MST_ID_W = (MST_AMT > 1) ? $clog2(MST_AMT) : 1;

   ar_state_e             ar_state;
   ar_state_e             ar_state_nxt;
   logic [MST_ID_W-1:0]   rr_ptr;
   logic [MST_ID_W-1:0]   grant;
   logic [MST_ID_W-1:0]   cand;
   logic [MST_AMT-1:0]    eligible;
   logic                  any_elig;
   logic                  load;
   logic                  ar_valid;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [MST_ID_W-1:0]   head;
   logic                  pop;
   logic                  s_rready;
   logic [MST_AMT-1:0]    ar_ready;
   logic [MST_AMT-1:0]    r_valid;
   logic [MST_AMT-1:0]    r_last;

   assign eligible = bus.dsp_ARVALID_i & ~bus.dsp_AR_outst_full_i;
   assign ar_valid = (ar_state == AR_PEND);
   assign load     = (~ar_valid | bus.s_ARREADY_i) & ~fifo_full & any_elig & ~ARESET_i;

   // First eligible dispatcher scanning circularly from rr_ptr.
   always_comb begin
      grant    = '0;
      cand     = '0;
      any_elig = 1'b0;
      for (int unsigned k = 0; k < MST_AMT; k++) begin
         cand = MST_ID_W'((32'(rr_ptr) + k) % MST_AMT);
         if (!any_elig && eligible[cand]) begin
            grant    = cand;
            any_elig = 1'b1;
         end
      end
   end

   always_comb begin
      ar_ready = '0;
      if (load) ar_ready[grant] = 1'b1;
   end

   always_comb begin
      ar_state_nxt = ar_state;
      if (load)                            ar_state_nxt = AR_PEND;
      else if (ar_valid && bus.s_ARREADY_i) ar_state_nxt = AR_IDLE;
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) ar_state <= AR_IDLE;
      else          ar_state <= ar_state_nxt;
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         rr_ptr          <= '0;
         bus.s_ARID_o    <= '0;
         bus.s_ARADDR_o  <= '0;
         bus.s_ARBURST_o <= '0;
         bus.s_ARLEN_o   <= '0;
         bus.s_ARSIZE_o  <= '0;
      end else if (load) begin
         rr_ptr          <= MST_ID_W'(rr_next(32'(grant), MST_AMT));
         bus.s_ARID_o    <= bus.dsp_ARID_i[32'(grant)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
         bus.s_ARADDR_o  <= bus.dsp_ARADDR_i[32'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
         bus.s_ARBURST_o <= bus.dsp_ARBURST_i[32'(grant)*TRANS_BURST_W +: TRANS_BURST_W];
         bus.s_ARLEN_o   <= bus.dsp_ARLEN_i[32'(grant)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
         bus.s_ARSIZE_o  <= bus.dsp_ARSIZE_i[32'(grant)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
   end

   sa_order_fifo #(
      .DEPTH (OUTSTANDING_AMT),
      .WIDTH (MST_ID_W)
   ) u_order_fifo (
      .clk   (ACLK_i),
      .rst   (ARESET_i),
      .push  (load),
      .pop   (pop),
      .din   (grant),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   // R demux: reset also blanks routing so stale FIFO contents never leak.
   always_comb begin
      r_valid  = '0;
      r_last   = '0;
      s_rready = 1'b0;
      if (!fifo_empty && !ARESET_i) begin
         r_valid[head] = bus.s_RVALID_i;
         r_last[head]  = bus.s_RLAST_i;
         s_rready      = bus.dsp_RREADY_i[head];
      end
   end

   assign pop              = bus.s_RVALID_i & s_rready & bus.s_RLAST_i;
   assign bus.s_ARVALID_o  = ar_valid;
   assign bus.dsp_ARREADY_o = ar_ready;
   assign bus.dsp_RVALID_o = r_valid;
   assign bus.dsp_RLAST_o  = r_last;
   assign bus.s_RREADY_o   = s_rready;
   assign bus.dsp_RID_o    = {MST_AMT{bus.s_RID_i}};
   assign bus.dsp_RDATA_o  = {MST_AMT{bus.s_RDATA_i}};

endmodule

// File: tb/tb_sa_read_arbiter.sv
// Randomized bench for sa_read_arbiter against a queue-based reference model
// of grant order, AR output register and in-order R routing.
module tb_sa_read_arbiter;
   import sa_read_arbiter_pkg::*;

   localparam int unsigned N   = 2;
   localparam int unsigned DEP = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 32;
   localparam int unsigned IDW = TRANS_MST_ID_W;
   localparam int unsigned BW  = TRANS_BURST_W;
   localparam int unsigned LW  = TRANS_DATA_LEN_W;
   localparam int unsigned SW  = TRANS_DATA_SIZE_W;
   localparam int unsigned NCYC = 4000;

   logic clk;
   logic rst;

   sa_read_arbiter_if #(.MST_AMT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sa_read_arbiter #(
      .MST_AMT         (N),
      .OUTSTANDING_AMT (DEP),
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW)
   ) dut (
      .ACLK_i   (clk),
      .ARESET_i (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   // Stimulus probabilities in percent.
   int unsigned p_arv, p_full, p_sarr, p_rv, p_rl, p_rr;

   // Reference model: AR output register contents plus outstanding order queue.
   bit              m_arvalid;
   logic [IDW-1:0]  m_id;
   logic [AW-1:0]   m_addr;
   logic [BW-1:0]   m_burst;
   logic [LW-1:0]   m_len;
   logic [SW-1:0]   m_size;
   int unsigned     m_ptr;
   int unsigned     m_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic bit rnd(input int unsigned pct);
      return $urandom_range(99) < pct;
   endfunction

   // Whether the slave AR stage takes a new request this cycle, and whose.
   function automatic void model_grant(output bit ld, output int unsigned g);
      bit found = 0;
      g = 0;
      for (int unsigned k = 0; k < N; k++) begin
         int unsigned idx = (m_ptr + k) % N;
         if (!found && bus.dsp_ARVALID_i[idx] && !bus.dsp_AR_outst_full_i[idx]) begin
            found = 1;
            g = idx;
         end
      end
      ld = found && !rst && (!m_arvalid || bus.s_ARREADY_i) && (m_q.size() < DEP);
   endfunction

   task automatic drive_random();
      for (int unsigned i = 0; i < N; i++) begin
         bus.dsp_ARVALID_i[i]       = rnd(p_arv);
         bus.dsp_AR_outst_full_i[i] = rnd(p_full);
         bus.dsp_RREADY_i[i]        = rnd(p_rr);
         bus.dsp_ARADDR_i[i*AW +: AW] = $urandom;
      end
      bus.dsp_ARID_i    = IDW*N'($urandom);
      bus.dsp_ARBURST_i = BW*N'($urandom);
      bus.dsp_ARLEN_i   = LW*N'($urandom);
      bus.dsp_ARSIZE_i  = SW*N'($urandom);
      bus.s_ARREADY_i   = rnd(p_sarr);
      bus.s_RVALID_i    = rnd(p_rv);
      bus.s_RLAST_i     = rnd(p_rl);
      bus.s_RID_i       = IDW'($urandom);
      bus.s_RDATA_i     = $urandom;
   endtask

   task automatic check_cycle();
      bit              ld;
      int unsigned     g;
      logic [N-1:0]    e_arr, e_rv, e_rl;
      logic            e_rr;
      logic [IDW*N-1:0] e_rid;
      logic [DW*N-1:0]  e_rdata;
      model_grant(ld, g);
      e_arr = '0;
      e_rv  = '0;
      e_rl  = '0;
      e_rr  = 1'b0;
      if (ld) e_arr[g] = 1'b1;
      if (!rst && m_q.size() > 0) begin
         e_rv[m_q[0]] = bus.s_RVALID_i;
         e_rl[m_q[0]] = bus.s_RLAST_i;
         e_rr         = bus.dsp_RREADY_i[m_q[0]];
      end
      for (int unsigned i = 0; i < N; i++) begin
         e_rid[i*IDW +: IDW] = bus.s_RID_i;
         e_rdata[i*DW +: DW] = bus.s_RDATA_i;
      end
      check_eq("dsp_arready", bus.dsp_ARREADY_o, e_arr);
      check_eq("s_arvalid",   bus.s_ARVALID_o,   m_arvalid);
      check_eq("s_arid",      bus.s_ARID_o,      m_id);
      check_eq("s_araddr",    bus.s_ARADDR_o,    m_addr);
      check_eq("s_arburst",   bus.s_ARBURST_o,   m_burst);
      check_eq("s_arlen",     bus.s_ARLEN_o,     m_len);
      check_eq("s_arsize",    bus.s_ARSIZE_o,    m_size);
      check_eq("dsp_rvalid",  bus.dsp_RVALID_o,  e_rv);
      check_eq("dsp_rlast",   bus.dsp_RLAST_o,   e_rl);
      check_eq("s_rready",    bus.s_RREADY_o,    e_rr);
      check_eq("dsp_rid",     bus.dsp_RID_o,     e_rid);
      check_eq("dsp_rdata",   bus.dsp_RDATA_o,   e_rdata);
   endtask

   task automatic model_update();
      bit          ld;
      int unsigned g;
      bit          pop;
      if (rst) begin
         m_arvalid = 0;
         m_id = '0; m_addr = '0; m_burst = '0; m_len = '0; m_size = '0;
         m_ptr = 0;
         m_q.delete();
      end else begin
         model_grant(ld, g);
         pop = (m_q.size() > 0) && bus.s_RVALID_i && bus.s_RLAST_i
               && bus.dsp_RREADY_i[m_q[0]];
         if (ld) begin
            m_arvalid = 1;
            m_id    = bus.dsp_ARID_i[g*IDW +: IDW];
            m_addr  = bus.dsp_ARADDR_i[g*AW +: AW];
            m_burst = bus.dsp_ARBURST_i[g*BW +: BW];
            m_len   = bus.dsp_ARLEN_i[g*LW +: LW];
            m_size  = bus.dsp_ARSIZE_i[g*SW +: SW];
            m_ptr   = (g + 1) % N;
         end else if (m_arvalid && bus.s_ARREADY_i) begin
            m_arvalid = 0;
         end
         if (pop) void'(m_q.pop_front());
         if (ld) m_q.push_back(g);
      end
   endtask

   task automatic set_phase(input int unsigned ph);
      case (ph)
         0: begin p_arv = 70;  p_full = 10; p_sarr = 70;  p_rv = 60; p_rl = 40; p_rr = 80;  end
         1: begin p_arv = 100; p_full = 0;  p_sarr = 100; p_rv = 50; p_rl = 50; p_rr = 100; end
         2: begin p_arv = 80;  p_full = 0;  p_sarr = 90;  p_rv = 5;  p_rl = 50; p_rr = 100; end
         3: begin p_arv = 80;  p_full = 5;  p_sarr = 15;  p_rv = 50; p_rl = 40; p_rr = 90;  end
         4: begin p_arv = 80;  p_full = 5;  p_sarr = 80;  p_rv = 70; p_rl = 30; p_rr = 30;  end
         default: begin p_arv = 90; p_full = 50; p_sarr = 70; p_rv = 50; p_rl = 40; p_rr = 80; end
      endcase
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      set_phase(1);
      drive_random();
      bus.dsp_ARVALID_i = '1;
      @(posedge clk);
      model_update();
      for (int unsigned c = 0; c < NCYC; c++) begin
         @(negedge clk);
         cyc = c;
         rst = (c < 2) || (c == 2100) || (c == 3333);
         set_phase((c / 500) % 6);
         drive_random();
         if (c < 2) bus.dsp_ARVALID_i = '1;
         #1;
         check_cycle();
         if (rst) begin
            check_eq("rst_arready", bus.dsp_ARREADY_o, '0);
            check_eq("rst_arvalid", bus.s_ARVALID_o,   1'b0);
            check_eq("rst_rready",  bus.s_RREADY_o,    1'b0);
         end
         @(posedge clk);
         model_update();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sa_read_arbiter.md
# sa_read_arbiter

Per-slave read arbiter of the AXI4 interconnect: shares one slave's AR channel among MST_AMT master-side dispatchers and routes the slave's R bursts back to the dispatcher that issued each request. Grant is round-robin over dispatchers with a pending, non-blocked AR. An order FIFO of granted dispatcher indices steers R traffic; the slave returns R bursts in AR acceptance order.

## Interface
- MST_AMT, 2, number of dispatchers (requesters)
- OUTSTANDING_AMT, 8, order FIFO depth = max outstanding read bursts at this slave
- DATA_WIDTH, 32, RDATA width
- ADDR_WIDTH, 32, ARADDR width
- TRANS_MST_ID_W, 5, ARID/RID width
- TRANS_BURST_W, 2, ARBURST width
- TRANS_DATA_LEN_W, 3, ARLEN width
- TRANS_DATA_SIZE_W, 3, ARSIZE width
- MST_ID_W, $clog2(MST_AMT), dispatcher index width
- ACLK_i  in  1  clock; one clock domain
- ARESET_i  in  1  reset, synchronous, active-high
- dsp_ARID_i / dsp_ARADDR_i / dsp_ARBURST_i / dsp_ARLEN_i / dsp_ARSIZE_i  in  field width*MST_AMT  packed AR fields, dispatcher i at slice i
- dsp_ARVALID_i  in  MST_AMT  AR request per dispatcher
- dsp_AR_outst_full_i  in  MST_AMT  dispatcher outstanding-full; masks its request
- dsp_ARREADY_o  out  MST_AMT  AR accept, one-hot or zero
- dsp_RID_o / dsp_RDATA_o  out  width*MST_AMT  R fields, broadcast to all slices
- dsp_RLAST_o / dsp_RVALID_o  out  MST_AMT  R last/valid per dispatcher
- dsp_RREADY_i  in  MST_AMT  R ready per dispatcher
- s_ARID_o / s_ARADDR_o / s_ARBURST_o / s_ARLEN_o / s_ARSIZE_o  out  field width  registered AR to slave
- s_ARVALID_o  out  1 ;  s_ARREADY_i  in  1
- s_RID_i / s_RDATA_i / s_RLAST_i / s_RVALID_i  in  R from slave ;  s_RREADY_o  out  1

## Operation
- eligible[i] = dsp_ARVALID_i[i] & ~dsp_AR_outst_full_i[i].
- Round-robin: search starts at rr_ptr, wraps at MST_AMT-1 -> 0; first eligible index = grant.
- load = (~s_ARVALID_o | s_ARREADY_i) & ~fifo_full & |eligible & ~ARESET_i.
- On load: AR output register captures dispatcher[grant] fields, s_ARVALID_o<=1; dsp_ARREADY_o[grant]=1 (combinational, same cycle); grant pushed into order FIFO; rr_ptr <= grant+1 (mod MST_AMT).
- s_ARREADY_i & s_ARVALID_o & ~load -> s_ARVALID_o<=0. Fields held stable while s_ARVALID_o & ~s_ARREADY_i.
- R routing: head = FIFO head index. FIFO non-empty: dsp_RVALID_o[head]=s_RVALID_i, dsp_RLAST_o[head]=s_RLAST_i, other bits 0; s_RREADY_o=dsp_RREADY_i[head]. FIFO empty: s_RREADY_o=0, all dsp_RVALID_o=0.
- Pop when s_RVALID_i & s_RREADY_o & s_RLAST_i.
- Push and pop same cycle: count unchanged; push blocked only by full (pre-pop), never by pop.
- Counter: count width $clog2(OUTSTANDING_AMT+1); wr/rd pointers wrap at OUTSTANDING_AMT-1.

## Timing
- AR latency: dispatcher handshake cycle N -> s_ARVALID_o high cycle N+1; back-to-back loads with s_ARREADY_i held high, one AR per cycle.
- R path: zero-cycle combinational pass-through, no bubbles between beats or bursts.
- Reset (sync, one edge): s_ARVALID_o=0, AR fields=0, rr_ptr=0, FIFO empty, count=0; hence dsp_ARREADY_o=0, dsp_RVALID_o=0, s_RREADY_o=0 while ARESET_i high.
- Reset mid-burst: outstanding entries discarded; no R beat routed afterwards until a new AR loads.
- FIFO full: no grant; pending dispatchers wait; load resumes the cycle after a pop.

## Structure
- Shared package/header: AXI field widths (TRANS_*), MST_AMT/OUTSTANDING_AMT defaults, common to all interconnect blocks.
- Sub-module sa_order_fifo: synchronous FIFO of MST_ID_W-bit entries, depth OUTSTANDING_AMT, push/pop/full/empty/head.
- Round-robin grant and R demux stay inline.

## Test plan
- Reset: ARESET_i high 2 cycles with dsp_ARVALID_i=2'b11 -> dsp_ARREADY_o=0, s_ARVALID_o=0, s_RREADY_o=0 throughout.
- Fairness: both dispatchers valid continuously, s_ARREADY_i=1 -> grants alternate 0,1,0,1; s_ARID_o follows dispatcher IDs in that order.
- Masking: dsp_AR_outst_full_i=2'b01, both valid -> only dispatcher 1 granted; clear full -> dispatcher 0 granted next.
- Order routing: AR from 1 (ARLEN=3), then from 0 (ARLEN=0); slave returns 4 beats + 1 beat -> beats 1-4 on dsp_RVALID_o[1], RLAST on 4th; 5th beat on [0] with RLAST.
- Backpressure: dsp_RREADY_i[head]=0 -> s_RREADY_o=0, FIFO count unchanged; s_ARREADY_i=0 for 3 cycles -> s_AR* fields stable.
- Full/simultaneous: OUTSTANDING_AMT=8, issue 8 ARs without R -> 9th request not granted; RLAST pop in same cycle as pending request -> grant next cycle; push+pop same cycle keeps count.
